// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store unit memory controller.
// Size codes follow the core's funct3[1:0] for sb/sh/sw and lb/lh/lw.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  // The illegal size code 2'b11 is reported as a misaligned access.
  function automatic logic misaligned_access(input logic [1:0] size,
                                             input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return addr_lo[0];
      SZ_WORD: return addr_lo != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_if.sv
// Data-memory bus seen by the controller: request/ack handshake with a word
// address, byte enables, and write data; read data is valid with mem_ack.
interface lsu_mem_if;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: byte enables and replicated store data
// going out, lane selection and sign/zero extension of load data coming back.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  input  logic        is_unsigned,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        sign_fill;

  assign byte_sel   = rdata[{addr_lo, 3'b000} +: 8];
  assign half_sel   = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  assign misaligned = misaligned_access(size, addr_lo);

  // NOTE: every output gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    be        = 4'b0000;
    wdata_rep = '0;
    rdata_ext = '0;
    sign_fill = 1'b0;
    case (size)
      SZ_BYTE: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        sign_fill = byte_sel[7] & ~is_unsigned;
        rdata_ext = {{24{sign_fill}}, byte_sel};
      end
      SZ_HALF: begin
        be        = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_rep = {2{wdata[15:0]}};
        sign_fill = half_sel[15] & ~is_unsigned;
        rdata_ext = {{16{sign_fill}}, half_sel};
      end
      SZ_WORD: begin
        be        = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store access controller: accepts one core request at a time, checks
// alignment, runs the bus req/ack handshake with a timeout, and returns a response.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_misaligned,
  output logic              resp_err,
  output logic              busy,
  lsu_mem_if.master         mem
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]      state;
  logic            we_q;
  logic [1:0]      size_q;
  logic            uns_q;
  logic [31:0]     addr_q;
  logic [31:0]     wdata_q;
  logic [TO_W-1:0] to_cnt;
  logic [31:0]     rdata_q;
  logic            mis_q;
  logic            err_q;

  logic            in_idle;
  logic            in_issue;
  logic            in_resp;

  logic [1:0]      al_size;
  logic [1:0]      al_addr_lo;
  logic [31:0]     al_wdata;
  logic            al_unsigned;
  logic [3:0]      al_be;
  logic [31:0]     al_wdata_rep;
  logic [31:0]     al_rdata_ext;
  logic            al_misaligned;

  assign in_idle  = state == IDLE;
  assign in_issue = state == ISSUE;
  assign in_resp  = state == RESP;

  // One aligner serves both phases: it checks the live request in IDLE and
  // steers the latched request for the rest of the transaction.
  assign al_size     = in_idle ? req_size        : size_q;
  assign al_addr_lo  = in_idle ? req_addr[1:0]   : addr_q[1:0];
  assign al_wdata    = in_idle ? req_wdata       : wdata_q;
  assign al_unsigned = in_idle ? req_unsigned    : uns_q;

  lsu_lane_align u_align (
    .size        (al_size),
    .addr_lo     (al_addr_lo),
    .wdata       (al_wdata),
    .rdata       (mem.mem_rdata),
    .is_unsigned (al_unsigned),
    .be          (al_be),
    .wdata_rep   (al_wdata_rep),
    .rdata_ext   (al_rdata_ext),
    .misaligned  (al_misaligned)
  );

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      to_cnt  <= '0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          to_cnt <= '0;
          if (req_valid) begin
            we_q    <= req_we;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            rdata_q <= '0;
            mis_q   <= al_misaligned;
            err_q   <= 1'b0;
            state   <= al_misaligned ? RESP : ISSUE;
          end
        end
        ISSUE: begin
          // An ack in the final timeout cycle still completes normally.
          if (mem.mem_ack) begin
            rdata_q <= we_q ? 32'h0 : al_rdata_ext;
            state   <= RESP;
          end else if (to_cnt == TO_LAST) begin
            err_q <= 1'b1;
            state <= RESP;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        RESP: begin
          to_cnt <= '0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Bus outputs are gated by state so reset drops mem_req without waiting for a clock.
  assign mem.mem_req   = in_issue;
  assign mem.mem_we    = in_issue & we_q;
  assign mem.mem_addr  = in_issue ? {addr_q[31:2], 2'b00} : 32'h0;
  assign mem.mem_be    = in_issue ? al_be : 4'b0000;
  assign mem.mem_wdata = in_issue ? al_wdata_rep : 32'h0;

  assign req_ready       = in_idle;
  assign busy            = in_issue | in_resp;
  assign resp_valid      = in_resp;
  assign resp_rdata      = in_resp ? rdata_q : 32'h0;
  assign resp_misaligned = in_resp & mis_q;
  assign resp_err        = in_resp & err_q;

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store access controller between the core's memory stage and the data-memory bus.
- Accepts one load or store request per transaction (valid/ready) and checks alignment.
- Generates byte enables and lane-replicated write data for sb/sh/sw, then runs a req/ack handshake with the memory.
- Returns sign- or zero-extended load data; `busy` is provided to stall the pipeline.

Parameters:
- TIMEOUT_CYCLES, 255: cycles in ISSUE without `mem_ack` before the access is abandoned with `resp_err`.
- TO_W, 8: width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous reset, active-low
- req_valid  in  1  core presents an access
- req_ready  out  1  controller can accept (high only in IDLE)
- req_we  in  1  1=store, 0=load
- req_size  in  2  00=byte, 01=half, 10=word, 11=illegal
- req_unsigned  in  1  load zero-extends (lbu/lhu)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_misaligned  out  1  with resp_valid: alignment fault or illegal size
- resp_err  out  1  with resp_valid: bus timeout
- busy  out  1  high in ISSUE and RESP
- mem_req  out  1  bus request, held until ack
- mem_we  out  1  bus write
- mem_addr  out  32  word address: {addr[31:2],2'b00}
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_ack  in  1  bus completion; may be asserted in the same cycle as mem_req
- mem_rdata  in  32  read word, valid with mem_ack

Behaviour:
- Reset (async assert, sync deassert assumed upstream):
  - State=IDLE; timeout counter cleared.
  - All outputs 0 except req_ready=1.
  - Asserting reset mid-ISSUE drops mem_req immediately; no response is issued.
- FSM IDLE:
  - req_ready=1.
  - On req_valid, latch we/size/unsigned/addr/wdata.
  - Illegal size, or misalignment (half with addr[0]=1; word with addr[1:0]!=0): go to RESP with misaligned=1. No bus access.
  - Otherwise go to ISSUE.
- FSM ISSUE:
  - mem_req=1; mem_we/addr/be/wdata driven from registers and held stable.
  - On mem_ack: capture the extracted load word, go to RESP.
  - Otherwise the counter increments each cycle. When it reaches TIMEOUT_CYCLES, deassert mem_req next cycle and go to RESP with err=1.
  - An ack arriving in the same cycle as the timeout wins: normal completion.
- FSM RESP:
  - resp_valid=1 for exactly one cycle, then return to IDLE.
  - Counter cleared; resp_* flags return to 0 afterwards.
  - req_ready=0, so back-to-back requests take at least 3 cycles each.
- Latency:
  - Accepted at edge N → mem_req high in cycle N+1.
  - Zero-wait ack in N+1 → resp_valid in N+2.
  - Misaligned access → resp_valid in N+1.
- Byte lanes (a = addr[1:0]):
  - Byte: be = 4'b0001<<a; wdata = {4{d[7:0]}}.
  - Half: be = 4'b0011<<{a[1],1'b0}; wdata = {2{d[15:0]}}.
  - Word: be = 4'b1111; wdata = d.
- Load extraction:
  - Byte: select mem_rdata lane a; sign-extend bit 7 unless req_unsigned.
  - Half: select lane pair a[1]; sign-extend bit 15 unless req_unsigned.
  - Word: pass through.
  - req_unsigned is ignored for stores and for words.
- req_valid is ignored outside IDLE. The core must hold its request until it sees req_ready.

Decomposition:
- Package lsu_pkg:
  - Size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - State encoding IDLE/ISSUE/RESP.
- Sub-module lsu_lane_align (combinational):
  - Inputs: size, addr[1:0], wdata, rdata, unsigned.
  - Outputs: be, replicated wdata, extended rdata, misaligned flag.
  - Instantiated once; the FSM and handshake stay in lsu_mem_ctrl.

Test Plan:
- Store byte, addr=0x1003, wdata=0x000000A5, ack next cycle → mem_addr=0x1000, mem_be=4'b1000, mem_wdata=0xA5A5A5A5, mem_we=1; resp_valid 2 cycles after accept, rdata=0.
- Load half, addr=0x2002, signed, mem_rdata=0x8001_1234 → resp_rdata=0xFFFF8001; same load with req_unsigned=1 → 0x00008001.
- Load word, addr=0x3001 → no mem_req ever; resp_valid next cycle with resp_misaligned=1. Store size=2'b11 at addr 0 → same result.
- Load word with 3 wait cycles before ack, mem_rdata=0xDEADBEEF → mem_req and mem_addr stable for 4 cycles; resp_rdata=0xDEADBEEF; busy high throughout.
- TIMEOUT_CYCLES=4, mem_ack tied 0 → mem_req drops after 4 ISSUE cycles; resp_err=1 for one cycle; req_ready=1 on the following cycle.
- rst_n asserted during ISSUE → mem_req=0 and busy=0 asynchronously; after release, req_ready=1 and a fresh sw at 0x10 (be=4'b1111) completes normally.
